// File: rtl/r2_cutoff_filter.sv
// r2_cutoff_filter: keeps pairs inside the cutoff sphere and queues them in a
// show-ahead FIFO for the force-evaluation stage. Upstream cannot stall, so
// full-FIFO arrivals are dropped and counted.
module r2_cutoff_filter #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned FIFO_ADDR_WIDTH = 3,
    parameter int unsigned ALMOST_FULL_TH  = 6,
    parameter logic [DATA_WIDTH-1:0] CUTOFF2 = 32'h42900000,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r2_valid,
    input  logic [DATA_WIDTH-1:0] r2,
    input  logic [DATA_WIDTH-1:0] dx,
    input  logic [DATA_WIDTH-1:0] dy,
    input  logic [DATA_WIDTH-1:0] dz,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_r2,
    output logic [DATA_WIDTH-1:0] out_dx,
    output logic [DATA_WIDTH-1:0] out_dy,
    output logic [DATA_WIDTH-1:0] out_dz,
    output logic                  almost_full,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  pair_in_cnt,
    output logic [CNT_WIDTH-1:0]  pair_acc_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam int unsigned DEPTH   = 2 ** FIFO_ADDR_WIDTH;
    localparam int unsigned OCC_W   = FIFO_ADDR_WIDTH + 1;
    localparam int unsigned ENTRY_W = 4 * DATA_WIDTH;
    localparam int unsigned MAG_MSB = DATA_WIDTH - 2;

    logic                       s1_valid;
    logic                       s1_pass;
    logic [ENTRY_W-1:0]         s1_data;
    logic [ENTRY_W-1:0]         mem [DEPTH];
    logic [ENTRY_W-1:0]         head;
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
    logic [OCC_W-1:0]           occ;

    logic             pass_c;
    logic             push_req_c;
    logic             pop_c;
    logic             full_c;
    logic             push_c;
    logic             drop_c;
    logic [OCC_W-1:0] occ_nxt_c;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_WIDTH'(1);
    endfunction

    // Cutoff test: positive, finite, non-zero and strictly below CUTOFF2.
    // For positive FP32 the magnitude bits order like an unsigned integer.
    always_comb begin
        pass_c = 1'b0;
        if (!r2[DATA_WIDTH-1] && (r2[MAG_MSB -: 8] != 8'hFF) && (r2[MAG_MSB:0] != '0)) begin
            pass_c = (r2[MAG_MSB:0] < CUTOFF2[MAG_MSB:0]);
        end
    end

    // Stage-2 push/pop decision; a full FIFO still accepts when the head leaves this cycle.
    always_comb begin
        push_req_c = s1_valid & s1_pass;
        pop_c      = out_valid & out_ready;
        full_c     = (occ == OCC_W'(DEPTH));
        push_c     = push_req_c & (~full_c | pop_c);
        drop_c     = push_req_c & full_c & ~pop_c;
        occ_nxt_c  = occ;
        if (push_c && !pop_c) begin
            occ_nxt_c = occ + OCC_W'(1);
        end else if (pop_c && !push_c) begin
            occ_nxt_c = occ - OCC_W'(1);
        end
    end

    // Stage-1 capture register and input counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid    <= 1'b0;
            s1_pass     <= 1'b0;
            s1_data     <= '0;
            pair_in_cnt <= '0;
        end else begin
            s1_valid <= r2_valid;
            s1_pass  <= pass_c;
            if (r2_valid) begin
                s1_data     <= {r2, dx, dy, dz};
                pair_in_cnt <= sat_inc(pair_in_cnt);
            end
        end
    end

    // FIFO control, status flags and accept/drop statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            out_valid    <= 1'b0;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            pair_acc_cnt <= '0;
            drop_cnt     <= '0;
        end else begin
            occ         <= occ_nxt_c;
            out_valid   <= (occ_nxt_c != '0);
            almost_full <= (occ_nxt_c >= OCC_W'(ALMOST_FULL_TH));
            if (push_c) begin
                wr_ptr       <= wr_ptr + FIFO_ADDR_WIDTH'(1);
                pair_acc_cnt <= sat_inc(pair_acc_cnt);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
            end
            if (drop_c) begin
                overflow <= 1'b1;
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    // FIFO storage; contents need no reset since out_valid gates the read side.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= s1_data;
        end
    end

    // Show-ahead head, forced to zero while empty.
    always_comb begin
        head   = out_valid ? mem[rd_ptr] : '0;
        out_r2 = head[4*DATA_WIDTH-1 -: DATA_WIDTH];
        out_dx = head[3*DATA_WIDTH-1 -: DATA_WIDTH];
        out_dy = head[2*DATA_WIDTH-1 -: DATA_WIDTH];
        out_dz = head[DATA_WIDTH-1 -: DATA_WIDTH];
    end

endmodule

// File: tb/tb_r2_cutoff_filter.sv
// Self-checking bench for r2_cutoff_filter: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_r2_cutoff_filter;

    typedef struct packed {
        logic [31:0] r2;
        logic [31:0] dx;
        logic [31:0] dy;
        logic [31:0] dz;
    } ent_t;

    typedef struct {
        logic [31:0] r2;
        bit          pass;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        r2_valid;
    logic [31:0] r2, dx, dy, dz;
    logic        out_ready;
    logic        out_valid, almost_full, overflow;
    logic [31:0] out_r2, out_dx, out_dy, out_dz;
    logic [15:0] pair_in_cnt, pair_acc_cnt, drop_cnt;

    logic        s_out_valid, s_almost_full, s_overflow;
    logic [31:0] s_out_r2, s_out_dx, s_out_dy, s_out_dz;
    logic [3:0]  s_pair_in_cnt, s_pair_acc_cnt, s_drop_cnt;

    always #5 clk = ~clk;

    r2_cutoff_filter dut (
        .clk(clk), .rst(rst), .r2_valid(r2_valid), .r2(r2), .dx(dx), .dy(dy), .dz(dz),
        .out_valid(out_valid), .out_ready(out_ready), .out_r2(out_r2), .out_dx(out_dx),
        .out_dy(out_dy), .out_dz(out_dz), .almost_full(almost_full), .overflow(overflow),
        .pair_in_cnt(pair_in_cnt), .pair_acc_cnt(pair_acc_cnt), .drop_cnt(drop_cnt)
    );

    r2_cutoff_filter #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .r2_valid(r2_valid), .r2(r2), .dx(dx), .dy(dy), .dz(dz),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_r2(s_out_r2), .out_dx(s_out_dx),
        .out_dy(s_out_dy), .out_dz(s_out_dz), .almost_full(s_almost_full), .overflow(s_overflow),
        .pair_in_cnt(s_pair_in_cnt), .pair_acc_cnt(s_pair_acc_cnt), .drop_cnt(s_drop_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    ent_t mq[$];
    bit   pend_v, pend_p;
    ent_t pend_e;
    int   in_cnt, acc_cnt, drp_cnt, pop_cnt;
    bit   ovf_m;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int sat(input int x, input int mx);
        return (x > mx) ? mx : x;
    endfunction

    // Decode FP32 to its real value and apply the cutoff sphere rule.
    function automatic bit ref_pass(input logic [31:0] b);
        int  e = int'(b[30:23]);
        int  m = int'(b[22:0]);
        real v;
        if (b[31] || e == 255) return 1'b0;
        if (e == 0) begin
            v = m / 8388608.0;
            e = 1;
        end else begin
            v = 1.0 + m / 8388608.0;
        end
        for (int k = e; k < 127; k++) v = v / 2.0;
        for (int k = 127; k < e; k++) v = v * 2.0;
        return (v > 0.0) && (v < 72.0);
    endfunction

    task automatic model_clear();
        mq.delete();
        pend_v  = 1'b0;
        pend_p  = 1'b0;
        in_cnt  = 0;
        acc_cnt = 0;
        drp_cnt = 0;
        ovf_m   = 1'b0;
    endtask

    // One clock: drive inputs, advance model, then compare all outputs.
    task automatic step(input bit v, input logic [31:0] r, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] z, input bit rdy);
        bit   pop;
        ent_t exp_head;
        r2_valid  = v;
        r2        = r;
        dx        = x;
        dy        = y;
        dz        = z;
        out_ready = rdy;
        pop = (mq.size() != 0) && rdy;
        @(posedge clk);
        if (pop) begin
            void'(mq.pop_front());
            pop_cnt++;
        end
        if (pend_v && pend_p) begin
            if (mq.size() < 8) begin
                mq.push_back(pend_e);
                acc_cnt++;
            end else begin
                ovf_m = 1'b1;
                drp_cnt++;
            end
        end
        pend_v = v;
        pend_p = v && ref_pass(r);
        pend_e = '{r2: r, dx: x, dy: y, dz: z};
        if (v) in_cnt++;
        #1;
        exp_head = (mq.size() != 0) ? mq[0] : '0;
        chk("out_valid", out_valid, mq.size() != 0);
        chk("out_data", {out_r2, out_dx, out_dy, out_dz}, exp_head);
        chk("almost_full", almost_full, mq.size() >= 6);
        chk("overflow", overflow, ovf_m);
        chk("pair_in_cnt", pair_in_cnt, sat(in_cnt, 65535));
        chk("pair_acc_cnt", pair_acc_cnt, sat(acc_cnt, 65535));
        chk("drop_cnt", drop_cnt, sat(drp_cnt, 65535));
        chk("sat_pair_in_cnt", s_pair_in_cnt, sat(in_cnt, 15));
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, rdy);
    endtask

    task automatic do_reset();
        r2_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_r2();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'h42900000 + $urandom_range(0, 4) - 2;
            2:       return {1'b0, 8'($urandom_range(100, 140)), 23'($urandom)};
            default: return 32'h40400000;
        endcase
    endfunction

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{32'h426C0000, 1'b1};
        tbl[1]  = '{32'h40400000, 1'b1};
        tbl[2]  = '{32'h42900000, 1'b0};
        tbl[3]  = '{32'h42A00000, 1'b0};
        tbl[4]  = '{32'h00000000, 1'b0};
        tbl[5]  = '{32'hBF800000, 1'b0};
        tbl[6]  = '{32'h7FC00000, 1'b0};
        tbl[7]  = '{32'h80000000, 1'b0};
        tbl[8]  = '{32'h7F800000, 1'b0};
        tbl[9]  = '{32'h428FFFFF, 1'b1};
        tbl[10] = '{32'h00000001, 1'b1};

        rst = 1'b0; r2_valid = 1'b0; out_ready = 1'b0;
        r2 = '0; dx = '0; dy = '0; dz = '0;
        model_clear();
        pop_cnt = 0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_almost_full", almost_full, 1'b0);
        chk("rst_out_r2", out_r2, 32'h0);
        chk("rst_pair_in_cnt", pair_in_cnt, 16'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Pass/reject table with the consumer always ready
        for (int i = 0; i < 11; i++) begin
            step(1'b1, tbl[i].r2, 32'hD000 + i, 32'hE000 + i, 32'hF000 + i, 1'b1);
            idle(1'b1);
            chk("tbl_emerge", out_valid, tbl[i].pass);
            if (tbl[i].pass) chk("tbl_r2", out_r2, tbl[i].r2);
            idle(1'b1);
            if (i == 6) begin
                chk("tbl_in_cnt", pair_in_cnt, 16'd7);
                chk("tbl_acc_cnt", pair_acc_cnt, 16'd2);
            end
        end

        // Fill to overflow with the consumer stalled
        do_reset();
        for (int j = 1; j <= 9; j++) begin
            step(1'b1, 32'h40400000, 32'h100 + j, 32'h200 + j, 32'h300 + j, 1'b0);
            if (j == 6) chk("af_before", almost_full, 1'b0);
            if (j == 7) chk("af_after6", almost_full, 1'b1);
        end
        idle(1'b0);
        chk("fill_out_valid", out_valid, 1'b1);
        chk("fill_overflow", overflow, 1'b1);
        chk("fill_drop_cnt", drop_cnt, 16'd1);
        chk("fill_acc_cnt", pair_acc_cnt, 16'd8);

        // Full FIFO: push lands in the same cycle as a pop
        step(1'b1, 32'h40400000, 32'h1FF, 32'h2FF, 32'h3FF, 1'b0);
        idle(1'b1);
        chk("fullpop_drop_cnt", drop_cnt, 16'd1);
        chk("fullpop_af", almost_full, 1'b1);
        pop_cnt = 0;
        for (int j = 0; j < 12; j++) idle(1'b1);
        chk("fullpop_drained", pop_cnt, 8);

        // Wrap-around with alternating ready
        do_reset();
        pop_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(i % 2 == 0, 32'h40400000, 32'h1000 + i, $urandom, $urandom, i % 2 == 1);
        end
        for (int i = 0; i < 10; i++) idle(1'b1);
        chk("wrap_drop_cnt", drop_cnt, 16'd0);
        chk("wrap_emerged", pop_cnt, 20);

        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rand_r2(), $urandom, $urandom, $urandom,
                 $urandom_range(0, 2) != 0);
        end

        // Reset mid-operation
        do_reset();
        for (int j = 0; j < 9; j++) step(1'b1, 32'h40400000, 32'h500 + j, 32'h0, 32'h0, 1'b0);
        idle(1'b0);
        for (int j = 0; j < 3; j++) idle(1'b1);
        chk("mid_queued", out_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("mid_out_valid", out_valid, 1'b0);
        chk("mid_almost_full", almost_full, 1'b0);
        chk("mid_overflow", overflow, 1'b0);
        chk("mid_in_cnt", pair_in_cnt, 16'd0);
        chk("mid_acc_cnt", pair_acc_cnt, 16'd0);
        chk("mid_drop_cnt", drop_cnt, 16'd0);
        r2_valid = 1'b0;
        model_clear();
        @(posedge clk);
        #1 rst = 1'b1;
        step(1'b1, 32'h40400000, 32'hABCD, 32'h1, 32'h2, 1'b1);
        chk("post_rst_lat1", out_valid, 1'b0);
        idle(1'b1);
        chk("post_rst_lat2", out_valid, 1'b1);
        chk("post_rst_dx", out_dx, 32'hABCD);
        idle(1'b1);

        // Counter saturation on the 4-bit instance
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        chk("sat_hold", s_pair_in_cnt, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
